// File: rtl/dff_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
package dff_reg_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_OWN
  } arb_state_e;

  // Owner/pointer index width; never narrower than one bit.
  function automatic int unsigned ow_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dff_reg_arbiter_if.sv
// Requester-side bundle of the shared-register arbiter.
interface dff_reg_arbiter_if
  import dff_reg_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned OW = ow_width(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       last;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       q;
  logic [OW-1:0]          owner;
  logic                   busy;

  modport master (
    output req, last, wdata,
    input  gnt, ack, q, owner, busy
  );

  modport slave (
    input  req, last, wdata,
    output gnt, ack, q, owner, busy
  );

endinterface

// File: rtl/dff_reg_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or after ptr, wrapping.
module rr_pick
  import dff_reg_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned OW    = ow_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [OW-1:0]    ptr_i,
  output logic             found_o,
  output logic [OW-1:0]    idx_o
);

  always_comb begin
    int unsigned k;
    logic [OW-1:0] k_idx;
    k       = 0;
    k_idx   = '0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k     = (32'(ptr_i) + i) % N_REQ;
      k_idx = OW'(k);
      if (!found_o && req_i[k_idx]) begin
        found_o = 1'b1;
        idx_o   = k_idx;
      end
    end
  end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter granting exclusive write ownership of one shared register.
module dff_reg_arbiter
  import dff_reg_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input logic              clk,
  input logic              res,
  dff_reg_arbiter_if.slave bus
);

  localparam int unsigned OW = ow_width(N_REQ);
  localparam int unsigned CW = $clog2(MAX_BEATS + 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic             pick_found;
  logic [OW-1:0]    pick_idx;
  logic             beat_acc;
  logic             beat_final;
  logic             release_now;
  logic [OW-1:0]    next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign beat_acc    = (state_q == ARB_OWN) && bus.req[owner_q] && gnt_q[owner_q];
  // Final beat: owner flags it, or this beat reaches the per-ownership cap.
  assign beat_final  = bus.last[owner_q] || (cnt_q == CW'(MAX_BEATS - 1));
  // Dropping req while owning is an abandon with nothing captured.
  assign release_now = (state_q == ARB_OWN) && (!beat_acc || beat_final);
  assign next_ptr    = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);

  // State register; every output is taken straight from a flop.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (pick_found) state_d = ARB_OWN;
      ARB_OWN:  if (release_now) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    ack_d   = '0;
    q_d     = q_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      ARB_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_found) begin
          gnt_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
          busy_d          = 1'b1;
          cnt_d           = '0;
        end
      end
      ARB_OWN: begin
        if (beat_acc) begin
          q_d            = bus.wdata[owner_q*WIDTH +: WIDTH];
          ack_d[owner_q] = 1'b1;
          cnt_d          = cnt_q + CW'(1);
        end
        // owner is kept after release so it still names the last owner.
        if (release_now) begin
          gnt_d  = '0;
          busy_d = 1'b0;
          ptr_d  = next_ptr;
        end
      end
      default: begin
        gnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.q     = q_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!res) $onehot0(gnt_q));
  a_ack_onehot0: assert property (@(posedge clk) disable iff (!res) $onehot0(ack_q));
  a_busy_gnt:    assert property (@(posedge clk) disable iff (!res) (|gnt_q) == busy_q);
  a_busy_state:  assert property (@(posedge clk) disable iff (!res)
                                  busy_q == (state_q == ARB_OWN));

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Self-checking bench: directed vector table, hand sequences, randomized model check.
module tb_dff_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int OW = 2;

  typedef struct {
    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic [OW-1:0]  owner;
    logic           busy;
  } vec_t;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  dff_reg_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  dff_reg_arbiter #(
    .N_REQ     (N),
    .WIDTH     (W),
    .MAX_BEATS (MB)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: who owns, how many beats so far, where the search starts.
  bit           m_own;
  int           m_owner, m_ptr, m_beats;
  logic [N-1:0] m_gnt, m_ack;
  logic [W-1:0] m_q;

  function automatic logic [N*W-1:0] pk(input logic [W-1:0] b0, input logic [W-1:0] b1,
                                        input logic [W-1:0] b2, input logic [W-1:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic bit_of(input logic [N-1:0] v, input int k);
    logic [N-1:0] t;
    t = v >> k;
    return t[0];
  endfunction

  function automatic vec_t mk(input logic [N-1:0] r, input logic [N-1:0] l,
                              input logic [N*W-1:0] d, input logic [N-1:0] g,
                              input logic [N-1:0] a, input logic [W-1:0] qq,
                              input logic [OW-1:0] o, input logic b);
    vec_t v;
    v.req = r; v.last = l; v.wdata = d; v.gnt = g; v.ack = a; v.q = qq; v.owner = o; v.busy = b;
    return v;
  endfunction

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*W-1:0] d);
    bus.req   = r;
    bus.last  = l;
    bus.wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [N-1:0] g, input logic [N-1:0] a,
                            input logic [W-1:0] qq, input logic [OW-1:0] o, input logic b);
    n_cmp++;
    if (bus.gnt !== g || bus.ack !== a || bus.q !== qq || bus.owner !== o || bus.busy !== b) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b ack=%b q=%h owner=%0d busy=%b, want gnt=%b ack=%b q=%h owner=%0d busy=%b",
               nm, bus.gnt, bus.ack, bus.q, bus.owner, bus.busy, g, a, qq, o, b);
    end
  endtask

  task automatic release_model();
    m_own = 1'b0;
    m_gnt = '0;
    m_ptr = (m_owner + 1) % N;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l,
                            input logic [N*W-1:0] d);
    logic [N*W-1:0] sh;
    m_ack = '0;
    if (!m_own) begin
      for (int i = 0; i < N; i++) begin
        if (!m_own && bit_of(r, (m_ptr + i) % N)) begin
          m_own   = 1'b1;
          m_owner = (m_ptr + i) % N;
          m_beats = 0;
        end
      end
      m_gnt = m_own ? (N'(1) << m_owner) : '0;
    end else if (!bit_of(r, m_owner)) begin
      release_model();
    end else begin
      sh    = d >> (W * m_owner);
      m_q   = sh[W-1:0];
      m_ack = N'(1) << m_owner;
      m_beats++;
      if (bit_of(l, m_owner) || m_beats == MB) release_model();
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic [N*W-1:0] bb;
    logic [N-1:0]   r, l;
    logic [N*W-1:0] d;

    bb = pk(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    // Single requester 1 (3 beats), then all four requesting 1-beat transfers.
    tbl.push_back(mk(4'b0010, 4'b0000, pk(0, 8'h11, 0, 0), 4'b0010, 4'b0000, 8'h00, 2'd1, 1'b1));
    tbl.push_back(mk(4'b0010, 4'b0000, pk(0, 8'h11, 0, 0), 4'b0010, 4'b0010, 8'h11, 2'd1, 1'b1));
    tbl.push_back(mk(4'b0010, 4'b0000, pk(0, 8'h22, 0, 0), 4'b0010, 4'b0010, 8'h22, 2'd1, 1'b1));
    tbl.push_back(mk(4'b0010, 4'b0010, pk(0, 8'h33, 0, 0), 4'b0000, 4'b0010, 8'h33, 2'd1, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0000, pk(0, 8'h44, 0, 0), 4'b0000, 4'b0000, 8'h33, 2'd1, 1'b0));
    tbl.push_back(mk(4'b1111, 4'b1111, bb, 4'b0100, 4'b0000, 8'h33, 2'd2, 1'b1));
    tbl.push_back(mk(4'b1111, 4'b1111, bb, 4'b0000, 4'b0100, 8'hB2, 2'd2, 1'b0));
    tbl.push_back(mk(4'b1111, 4'b1111, bb, 4'b1000, 4'b0000, 8'hB2, 2'd3, 1'b1));
    tbl.push_back(mk(4'b1111, 4'b1111, bb, 4'b0000, 4'b1000, 8'hB3, 2'd3, 1'b0));
    tbl.push_back(mk(4'b1111, 4'b1111, bb, 4'b0001, 4'b0000, 8'hB3, 2'd0, 1'b1));
    tbl.push_back(mk(4'b1111, 4'b1111, bb, 4'b0000, 4'b0001, 8'hB0, 2'd0, 1'b0));
    tbl.push_back(mk(4'b1111, 4'b1111, bb, 4'b0010, 4'b0000, 8'hB0, 2'd1, 1'b1));
    tbl.push_back(mk(4'b1111, 4'b1111, bb, 4'b0000, 4'b0010, 8'hB1, 2'd1, 1'b0));
    tbl.push_back(mk(4'b1111, 4'b1111, bb, 4'b0100, 4'b0000, 8'hB1, 2'd2, 1'b1));
    tbl.push_back(mk(4'b0000, 4'b0000, bb, 4'b0000, 4'b0000, 8'hB1, 2'd2, 1'b0));

    res = 1'b0;
    drive('0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
    res = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].last, tbl[i].wdata);
      tick();
      expect_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].ack, tbl[i].q, tbl[i].owner,
                 tbl[i].busy);
    end

    // Forced release: ptr=3, requester 3 streams without last while 0 waits.
    drive(4'b1001, 4'b0000, pk(8'hE0, 0, 0, 8'h31));
    tick();
    expect_out("force_grant", 4'b1000, 4'b0000, 8'hB1, 2'd3, 1'b1);
    for (int b = 1; b <= MB; b++) begin
      drive(4'b1001, 4'b0000, pk(8'hE0, 0, 0, 8'(8'h30 + b)));
      tick();
      expect_out($sformatf("force_beat%0d", b), (b < MB) ? 4'b1000 : 4'b0000, 4'b1000,
                 8'(8'h30 + b), 2'd3, (b < MB));
    end
    tick();
    expect_out("force_next", 4'b0001, 4'b0000, 8'h34, 2'd0, 1'b1);

    // Abandon: owner 0 writes one beat and drops req; requester 2 follows.
    drive(4'b0001, 4'b0000, pk(8'h5A, 0, 0, 0));
    tick();
    expect_out("abandon_beat", 4'b0001, 4'b0001, 8'h5A, 2'd0, 1'b1);
    drive(4'b0100, 4'b0000, pk(8'hFF, 0, 8'h66, 0));
    tick();
    expect_out("abandon_rel", 4'b0000, 4'b0000, 8'h5A, 2'd0, 1'b0);
    tick();
    expect_out("abandon_next", 4'b0100, 4'b0000, 8'h5A, 2'd2, 1'b1);
    drive(4'b0100, 4'b0100, pk(0, 0, 8'h77, 0));
    tick();
    expect_out("own2_last", 4'b0000, 4'b0100, 8'h77, 2'd2, 1'b0);

    // Non-owner isolation: requester 3 toggles everything while 1 owns.
    drive(4'b0010, 4'b0000, '0);
    tick();
    expect_out("iso_grant", 4'b0010, 4'b0000, 8'h77, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive({i[0], 3'b010}, 4'b1000, pk(0, 8'(8'hC1 + i), 0, 8'($urandom)));
      tick();
      expect_out($sformatf("iso_beat%0d", i), 4'b0010, 4'b0010, 8'(8'hC1 + i), 2'd1, 1'b1);
    end
    drive(4'b1010, 4'b0010, pk(0, 8'hD0, 0, 8'h99));
    tick();
    expect_out("iso_last", 4'b0000, 4'b0010, 8'hD0, 2'd1, 1'b0);
    drive('0, '0, '0);
    tick();
    expect_out("idle_hold", 4'b0000, 4'b0000, 8'hD0, 2'd1, 1'b0);

    // Asynchronous reset in the middle of an ownership by requester 2.
    drive(4'b0100, 4'b0000, pk(0, 0, 8'hA5, 0));
    tick();
    expect_out("rst_grant", 4'b0100, 4'b0000, 8'hD0, 2'd2, 1'b1);
    tick();
    expect_out("rst_beat", 4'b0100, 4'b0100, 8'hA5, 2'd2, 1'b1);
    #2 res = 1'b0;
    #1 expect_out("rst_async", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
    #2 res = 1'b1;
    drive(4'b1111, 4'b0000, '0);
    tick();
    expect_out("rst_after", 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b1);

    // Randomized traffic against the model, starting from a fresh reset.
    drive('0, '0, '0);
    #1 res = 1'b0;
    #2 res = 1'b1;
    m_own = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0;
    m_gnt = '0; m_ack = '0; m_q = '0;
    for (int c = 0; c < 400; c++) begin
      r = N'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) l[k] = ($urandom_range(0, 2) == 0);
      d = $urandom;
      model_step(r, l, d);
      drive(r, l, d);
      tick();
      expect_out($sformatf("rand%0d", c), m_gnt, m_ack, m_q, 2'(m_owner), m_own);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dff_reg_arbiter.md
# dff_reg_arbiter

Round-robin arbiter that shares one WIDTH-bit register (a bank of D flip-flops with asynchronous clear) among N_REQ requesters. Each requester raises a request, receives exclusive ownership, writes one or more data beats into the shared register, and releases it. The block sits between the requesting datapaths and the shared storage, sequencing every write so that exactly one requester drives the register at a time.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, shared register width
- MAX_BEATS, 16, maximum beats per ownership before forced release (1..255)

- clk  in  1  rising-edge clock
- res  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request/valid; held high while owning and writing
- last  in  N_REQ  per-requester final-beat flag; sampled only with an accepted beat
- wdata  in  N_REQ*WIDTH  per-requester data; slice k = wdata[k*WIDTH +: WIDTH]
- gnt  out  N_REQ  one-hot grant (registered)
- ack  out  N_REQ  one-hot, one-cycle pulse marking a captured beat
- q  out  WIDTH  shared register contents
- owner  out  OW = max(1,$clog2(N_REQ))  index of current/last owner
- busy  out  1  high while in OWN

## Operation
- States: IDLE, OWN.
- Reset (res=0, asynchronous, any time including mid-ownership): state=IDLE, q=0, gnt=0, ack=0, owner=0, busy=0, ptr=0, beat count=0.
- IDLE: if any req bit is set, pick the first set bit searching cyclically from ptr upward (ptr, ptr+1, ... mod N_REQ). Then gnt[k]=1, owner=k, busy=1, beat count=0, and state goes to OWN. With no req, stay in IDLE with gnt=0.
- OWN, beat accepted (req[owner]=1, gnt[owner]=1): q <= wdata slice owner, ack[owner]=1 for one cycle, beat count increments.
- Release happens on any of the following:
  - the accepted beat has last[owner]=1;
  - the accepted beat is beat number MAX_BEATS (forced release, and that beat is still captured);
  - req[owner]=0 while in OWN (abandon, nothing captured).
- On release: gnt=0, busy=0, state=IDLE, ptr=(owner+1) mod N_REQ. owner keeps its value.
- req bits of non-owners are ignored while in OWN. Their wdata and last inputs are never sampled.
- q holds its value whenever no beat is accepted.

## Timing
- Request-to-grant latency: req rising in IDLE before edge t gives gnt visible after edge t.
- Beat capture: q and ack update on the same edge that accepts the beat. They are visible the cycle after req, wdata and gnt are all present.
- Every release is followed by exactly one IDLE cycle with gnt=0 before the next grant. There is no back-to-back grant.
- Throughput: one beat per cycle while owning. An N-beat transfer occupies 1 (grant) + N cycles, plus 1 IDLE cycle.
- Simultaneous events:
  - Release and a new request on the same edge: the new request is arbitrated on the following IDLE edge, using the updated ptr.
  - last and the MAX_BEATS limit coinciding produce a single release.
- gnt and ack are always zero or one-hot. No output glitches, because all outputs come straight from registers.

## Structure
- Package dff_reg_arbiter_pkg: state enum (ARB_IDLE, ARB_OWN) and the OW width localparam function.
- Beat counter width: $clog2(MAX_BEATS+1).
- Sub-module rr_pick: purely combinational. Inputs are the req vector and ptr; outputs are a found flag and the selected index. It is instantiated once. All state lives in the top module.

## Test plan
- Reset mid-OWN: owner=2 writing 8'hA5, drop res for 3 ns between edges -> q=0, gnt=0, busy=0, owner=0 immediately; after release of res, requester 0 wins first.
- Single requester: req[1]=1 with data 8'h11, 8'h22, 8'h33 (last on 8'h33) -> gnt[1] one edge after req; q sequence 11/22/33; ack[1] pulses 3 times; then one IDLE cycle; ptr=2.
- Round-robin fairness: req=4'b1111 held, every transfer 1 beat with last=1 -> grant order 0,1,2,3,0; one idle cycle between grants.
- Forced release: MAX_BEATS=4, req[3] streaming without last -> exactly 4 beats captured, then gnt[3]=0; requester 0, pending since the start, is granted next.
- Abandon: owner 0 drops req after 1 beat with no last -> release, q keeps the first beat's value, no further ack; req[2] is granted 2 edges later.
- Non-owner isolation: while owner=1, toggle wdata, last and req of requester 3 -> q and ack are unaffected, and gnt stays 4'b0010.
